mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single main-memory block port between the instruction cache (read-only)
//  and the data cache (read/write).
//  Sits between both cache controllers and data memory; each cache sees a private
//  read/write + busyWait port.
//  One transaction in flight at a time; requesters stall on busyWait until served.
// PARAMETERS
//  ADDR_W     6   block address width (word address >> 2)
//  DATA_W     32  block width in bits
//  DPRIORITY  1   1: data cache always wins ties; 0: round-robin on ties
// PORTS
//  CLK           in   1       clock, all state updates on posedge
//  RESET         in   1       synchronous, active-high
//  i_read        in   1       icache read request, level, held until i_busywait low
//  i_address     in   ADDR_W  icache block address
//  i_readdata    out  DATA_W  icache read block, valid while i_busywait low after grant
//  i_busywait    out  1       icache stall
//  d_read        in   1       dcache read request, level
//  d_write       in   1       dcache write request, level
//  d_address     in   ADDR_W  dcache block address
//  d_writedata   in   DATA_W  dcache write block
//  d_readdata    out  DATA_W  dcache read block
//  d_busywait    out  1       dcache stall
//  mem_read      out  1       memory read strobe
//  mem_write     out  1       memory write strobe
//  mem_address   out  ADDR_W  memory block address
//  mem_writedata out  DATA_W  memory write block
//  mem_readdata  in   DATA_W  memory read block
//  mem_busywait  in   1       memory busy; low with strobe high after issue cycle = complete
// BEHAVIOUR
//  - Requests: i_req = i_read; d_req = d_read | d_write.
//    d_read & d_write both high is treated as a write.
//  - States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
//  - IDLE: strobes low.
//    - Neither request: stay in IDLE.
//    - One request: go to SERVE_x.
//    - Both: DPRIORITY=1 picks D. DPRIORITY=0 picks the port opposite last_grant.
//    - On the transition, latch address, write data and op into internal registers.
//    - Update last_grant.
//  - SERVE_x: mem_read/mem_write driven from latched op; mem_address/mem_writedata from
//    latches.
//    - issued_r is set at the end of the first SERVE cycle.
//    - Completion: issued_r==1 && mem_busywait==0. On completion, capture mem_readdata
//      into x_readdata (reads only) and go to RESP_x.
//  - RESP_x: strobes low, exactly one cycle, then IDLE. x_readdata is held until the next
//    read completion for that port.
//  - x_busywait = x_req & ~(state==RESP_x). Combinational, so a rising request stalls
//    in the same cycle.
//  - Latency, request seen in IDLE to busywait low = 2 + memory service cycles.
//    No back-to-back: at least one IDLE cycle between grants.
//  - Requests arriving during SERVE/RESP wait; they are never dropped and never preempt.
//  - Requester drops its request mid-SERVE: the memory transaction still completes; RESP
//    is taken; no data is delivered to another port.
//  - Reset values (at the posedge with RESET=1), also on reset mid-operation:
//    - state=IDLE, issued_r=0, last_grant=I.
//    - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
//    - i_readdata=0, d_readdata=0.
//    - The in-flight memory transaction is abandoned.
//    - busywaits follow their requests while RESET is high.
//  - Ties under DPRIORITY=0 after reset go to D first, since last_grant=I.
//  - No combinational path from mem_busywait to mem_read/mem_write.
// TESTING
//  - Memory model: busywait high 5 cycles after strobe, then low 1 cycle.
//  - Reset: RESET=1 two cycles with i_read=1 -> strobes 0, readdata 0, i_busywait=1,
//    state IDLE.
//  - Lone icache read, addr 6'h0A, mem returns 32'hDEADBEEF -> mem_read=1 addr 0A;
//    i_busywait low for 1 cycle, 7 cycles after request; i_readdata=DEADBEEF;
//    d_busywait=0.
//  - Lone dcache write, addr 6'h03, data 32'h12345678 -> mem_write=1 with those values;
//    mem_read=0; d_busywait low after 7 cycles.
//  - Simultaneous i_read(05) + d_read(09), DPRIORITY=1 -> D served first; I issued after
//    1 IDLE cycle; i_busywait stays high ~14 cycles.
//  - Repeat the tie test with DPRIORITY=0, three successive ties -> grant order D, I, D.
//  - RESET pulsed during SERVE_D third cycle -> strobes 0 next edge; re-request afterwards
//    served normally with fresh data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one main-memory block port between the read-only instruction cache
// and the read/write data cache. Only one memory transaction is in flight at a time.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int DPRIORITY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SERVE_I = 3'd1;
    localparam logic [2:0] SERVE_D = 3'd2;
    localparam logic [2:0] RESP_I  = 3'd3;
    localparam logic [2:0] RESP_D  = 3'd4;

    // Handshake: a cache holds its request level-high; the request is accepted and
    // answered in the single cycle its busywait is low (RESP state). Toward memory the
    // strobe stays high until mem_busywait is low after the issue cycle.

    logic [2:0]        state;
    logic              issued_r;
    logic              last_grant;   // 0 = icache, 1 = dcache
    logic              op_write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic i_req;
    logic d_req;
    logic serving;
    logic pick_d;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_comb begin
        pick_d = 1'b0;
        if (d_req && !i_req)
            pick_d = 1'b1;
        else if (d_req && i_req)
            pick_d = (DPRIORITY != 0) ? 1'b1 : ~last_grant;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            issued_r   <= 1'b0;
            last_grant <= 1'b0;
            op_write_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            i_readdata <= '0;
            d_readdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issued_r <= 1'b0;
                    if (pick_d) begin
                        state      <= SERVE_D;
                        last_grant <= 1'b1;
                        addr_r     <= d_address;
                        wdata_r    <= d_writedata;
                        op_write_r <= d_write;
                    end else if (i_req) begin
                        state      <= SERVE_I;
                        last_grant <= 1'b0;
                        addr_r     <= i_address;
                        wdata_r    <= '0;
                        op_write_r <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    issued_r <= 1'b1;
                    // The busywait seen in the issue cycle predates our strobe, so ignore it.
                    if (issued_r && !mem_busywait) begin
                        issued_r <= 1'b0;
                        if (state == SERVE_I) begin
                            state      <= RESP_I;
                            i_readdata <= mem_readdata;
                        end else begin
                            state <= RESP_D;
                            if (!op_write_r)
                                d_readdata <= mem_readdata;
                        end
                    end
                end
                RESP_I, RESP_D: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    assign mem_read      = serving & ~op_write_r;
    assign mem_write     = serving & op_write_r;
    assign mem_address   = addr_r;
    assign mem_writedata = wdata_r;
    assign i_busywait    = i_req & (state != RESP_I);
    assign d_busywait    = d_req & (state != RESP_D);
    assign dbg_state     = state;

endmodule
